decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 101 ++++++++++
 tb/tb_decode_stage.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline register with valid/ready handshake; optional DECODE_ILLEGAL_EN adds out_illegal
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [31:0] out_imm,
  output logic        out_reg_we,
`ifdef DECODE_ILLEGAL_EN
  output logic        out_illegal,
`endif
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_SYS = 7'b1110011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  logic [6:0] opc;
  logic is_r, is_i, is_s, is_b, is_u, is_j, wr_op, accept;
  logic [31:0] d_imm;
  logic [4:0] d_rs1, d_rs2;
  logic d_we;
  assign opc = in_instr[6:0];
  assign is_r = opc == OP_R;
  assign is_i = opc == OP_IMM || opc == OP_LOAD || opc == OP_JALR || opc == OP_SYS;
  assign is_s = opc == OP_STORE;
  assign is_b = opc == OP_BR;
  assign is_u = opc == OP_LUI || opc == OP_AUIPC;
  assign is_j = opc == OP_JAL;
  assign wr_op = is_r || is_u || is_j || (is_i && opc != OP_SYS);
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  // Immediate generation by format; R-type and unknown opcodes yield zero
  always_comb begin
    d_imm = is_i ? {{20{in_instr[31]}}, in_instr[31:20]}
          : is_s ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]}
          : is_b ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}
          : is_u ? {in_instr[31:12], 12'b0}
          : is_j ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}
          : 32'd0;
  end
  assign d_rs1 = (is_u || is_j) ? 5'd0 : in_instr[19:15];
  assign d_rs2 = (is_i || is_u || is_j) ? 5'd0 : in_instr[24:20];
  assign d_we = wr_op && in_instr[11:7] != 5'd0;
  // Register-file addresses track the instruction that will occupy the output register next cycle
  assign rf_rs1 = accept ? d_rs1 : out_rs1;
  assign rf_rs2 = accept ? d_rs2 : out_rs2;
`ifdef DECODE_ILLEGAL_EN
  logic d_illegal;
  assign d_illegal = in_instr[1:0] != 2'b11 || !(is_r || is_i || is_s || is_b || is_u || is_j);
  // Illegal flag registered alongside the other decoded fields
  always_ff @(posedge clk or posedge reset)
    if (reset) out_illegal <= 1'b0;
    else if (!flush && accept) out_illegal <= d_illegal;
`endif
  // Output register: flush beats accept, accept beats drain; fields only change on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_pc     <= 32'd0;
      out_opcode <= NOP_INSTR[6:0];
      out_funct3 <= NOP_INSTR[14:12];
      out_funct7 <= NOP_INSTR[31:25];
      out_rd     <= 5'd0;
      out_rs1    <= 5'd0;
      out_rs2    <= 5'd0;
      out_imm    <= 32'd0;
      out_reg_we <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_pc     <= in_pc;
      out_opcode <= in_instr[6:0];
      out_funct3 <= in_instr[14:12];
      out_funct7 <= in_instr[31:25];
      out_rd     <= in_instr[11:7];
      out_rs1    <= d_rs1;
      out_rs2    <= d_rs2;
      out_imm    <= d_imm;
      out_reg_we <= d_we;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector self-checking bench for decode_stage
module tb_decode_stage;
  logic clk, reset, in_valid, in_ready, flush, out_valid, out_ready, out_reg_we;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0] out_opcode, out_funct7;
  logic [2:0] out_funct3;
  logic [4:0] out_rd, out_rs1, out_rs2, rf_rs1, rf_rs2;
`ifdef DECODE_ILLEGAL_EN
  logic out_illegal;
`endif
  int total = 0, bad = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_reg_we(out_reg_we),
`ifdef DECODE_ILLEGAL_EN
    .out_illegal(out_illegal),
`endif
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        we, ill;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    vecs[0] = '{32'hFFF08293, 5'd1, 5'd0, 5'd5,  32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[1] = '{32'h0021A423, 5'd3, 5'd2, 5'd8,  32'h00000008, 1'b0, 1'b0};
    vecs[2] = '{32'h12345037, 5'd0, 5'd0, 5'd0,  32'h12345000, 1'b0, 1'b0};
    vecs[3] = '{32'h008000EF, 5'd0, 5'd0, 5'd1,  32'h00000008, 1'b1, 1'b0};
    vecs[4] = '{32'hFE208EE3, 5'd1, 5'd2, 5'd29, 32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[5] = '{32'h002081B3, 5'd1, 5'd2, 5'd3,  32'h00000000, 1'b1, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 32'h00000000, 1'b0, 1'b1};
    reset = 1; in_valid = 1; in_instr = 32'hFFF08293; in_pc = 32'h55; flush = 0; out_ready = 1;
    tick; tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_opcode", out_opcode, 7'h13);
    chk("rst_funct3", out_funct3, 0);
    chk("rst_funct7", out_funct7, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_we", out_reg_we, 0);
    reset = 0; in_valid = 0;
    #1 chk("ready_after_rst", in_ready, 1);
    tick;
    chk("no_accept_in_rst", out_valid, 0);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 4 * i;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      chk($sformatf("v%0d_rf_rs1", i), rf_rs1, vecs[i].rs1);
      chk($sformatf("v%0d_rf_rs2", i), rf_rs2, vecs[i].rs2);
      tick;
      w = vecs[i].instr;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 4 * i);
      chk($sformatf("v%0d_opcode", i), out_opcode, w[6:0]);
      chk($sformatf("v%0d_funct3", i), out_funct3, w[14:12]);
      chk($sformatf("v%0d_funct7", i), out_funct7, w[31:25]);
      chk($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
      chk($sformatf("v%0d_rs1", i), out_rs1, vecs[i].rs1);
      chk($sformatf("v%0d_rs2", i), out_rs2, vecs[i].rs2);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_we", i), out_reg_we, vecs[i].we);
`ifdef DECODE_ILLEGAL_EN
      chk($sformatf("v%0d_illegal", i), out_illegal, vecs[i].ill);
`endif
    end
    in_valid = 0;
    tick;
    chk("drain_valid", out_valid, 0);
    chk("drain_rd_held", out_rd, 31);
    in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h2000;
    tick;
    chk("stall_pre_valid", out_valid, 1);
    out_ready = 0; in_instr = 32'h0021A423; in_pc = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
      chk($sformatf("stall%0d_rf_rs1", c), rf_rs1, 1);
      chk($sformatf("stall%0d_rf_rs2", c), rf_rs2, 2);
      tick;
      chk($sformatf("stall%0d_valid", c), out_valid, 1);
      chk($sformatf("stall%0d_rd", c), out_rd, 3);
      chk($sformatf("stall%0d_pc", c), out_pc, 32'h2000);
    end
    out_ready = 1;
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_rf_rs1", rf_rs1, 3);
    tick;
    chk("release_pc", out_pc, 32'h2004);
    chk("release_imm", out_imm, 8);
    flush = 1; in_instr = 32'hFFF08293; in_pc = 32'h3000;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_rf_rs1", rf_rs1, 3);
    tick;
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_imm_held", out_imm, 8);
    chk("flush_pc_held", out_pc, 32'h2004);
    in_valid = 1;
    tick;
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_imm", out_imm, 32'hFFFFFFFF);
    in_instr = 32'h12345037; reset = 1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_pc", out_pc, 0);
    tick;
    chk("mid_rst_opcode", out_opcode, 7'h13);
    chk("mid_rst_imm", out_imm, 0);
    reset = 0; in_valid = 0;
    #1 chk("mid_rst_ready", in_ready, 1);
    tick;
    chk("mid_rst_valid_after", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
